// File: rtl/alu_writeback.sv
// ALU result writeback: one-cycle register-file commit plus an in-order store
// buffer drained to the data-memory port over a req/ack handshake.
module alu_writeback #(
    parameter int SB_DEPTH = 4,
    parameter int XLEN     = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_store,
    input  logic [XLEN-1:0] in_data,
    input  logic [4:0]      in_dest,
    input  logic [XLEN-1:0] in_addr,
    input  logic [1:0]      in_size,
    output logic            rf_wr_en,
    output logic [4:0]      rf_wr_idx,
    output logic [XLEN-1:0] rf_wr_data,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [1:0]      mem_size,
    input  logic            mem_ack,
    output logic            sb_empty,
    output logic            misalign
);
    localparam int PW = $clog2(SB_DEPTH);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW:0]     r_count;
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [XLEN-1:0] r_sb_addr [SB_DEPTH];
    logic [XLEN-1:0] r_sb_data [SB_DEPTH];
    logic [1:0]      r_sb_size [SB_DEPTH];

    logic            r_rf_wr_en, r_mem_req, r_misalign;
    logic [4:0]      r_rf_wr_idx;
    logic [XLEN-1:0] r_rf_wr_data, r_mem_addr, r_mem_wdata;
    logic [1:0]      r_mem_size;

    logic            w_accept, w_push, w_pop, w_load, w_misal;
    logic [XLEN-1:0] w_data_masked;

    // Ready depends only on registered count, so a same-cycle pop never opens a full buffer.
    assign in_ready = (r_count < (PW+1)'(SB_DEPTH));
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && in_is_store && !w_misal;

    always_comb begin
        w_misal = 1'b0;
        case (in_size)
            2'd1:    w_misal = in_addr[0];
            2'd2:    w_misal = |in_addr[1:0];
            2'd3:    w_misal = |in_addr[2:0];
            default: w_misal = 1'b0;
        endcase
    end

    always_comb begin
        w_data_masked = '0;
        case (in_size)
            2'd0:    w_data_masked[7:0]  = in_data[7:0];
            2'd1:    w_data_masked[15:0] = in_data[15:0];
            2'd2:    w_data_masked[31:0] = in_data[31:0];
            default: w_data_masked       = in_data;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: if (r_count != '0) begin
                w_load      = 1'b1;
                w_state_nxt = S_REQ;
            end
            S_REQ: if (mem_ack) begin
                w_pop       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Buffer storage carries no reset; validity is tracked solely by count/pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sb_addr[r_wptr] <= in_addr;
            r_sb_data[r_wptr] <= w_data_masked;
            r_sb_size[r_wptr] <= in_size;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_size  <= '0;
        end else if (w_load) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= r_sb_addr[r_rptr];
            r_mem_wdata <= r_sb_data[r_rptr];
            r_mem_size  <= r_sb_size[r_rptr];
        end else if (w_pop) begin
            r_mem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rf_wr_en   <= 1'b0;
            r_rf_wr_idx  <= '0;
            r_rf_wr_data <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_rf_wr_en <= w_accept && !in_is_store && (in_dest != 5'd0);
            r_misalign <= w_accept && in_is_store && w_misal;
            if (w_accept && !in_is_store) begin
                r_rf_wr_idx  <= in_dest;
                r_rf_wr_data <= in_data;
            end
        end
    end

    assign rf_wr_en   = r_rf_wr_en;
    assign rf_wr_idx  = r_rf_wr_idx;
    assign rf_wr_data = r_rf_wr_data;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_size   = r_mem_size;
    assign misalign   = r_misalign;
    assign sb_empty   = (r_count == '0) && (r_state == S_IDLE);
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Consumer end of the ALU result interface: takes each retired ALU result and commits it.
- Register-destined results are written to the register file one cycle after acceptance.
- Store results are queued in an in-order store buffer and drained to the data-memory port using a req/ack handshake.
- Sits between the ALU and the register file / data-memory bus; also exposes back-pressure and a store-buffer-empty flag for fence handling.

Parameters:
- SB_DEPTH, 4, number of store-buffer entries; power of two, minimum 2.
- XLEN, 64, datapath width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  block can accept a result.
- in_is_store  input  1  result is a store; otherwise a register write.
- in_data  input  XLEN  register write value, or store data (low bytes significant).
- in_dest  input  5  destination register index; ignored for stores.
- in_addr  input  XLEN  store effective address.
- in_size  input  2  store size: 0=byte, 1=half, 2=word, 3=double.
- rf_wr_en  output  1  register-file write strobe.
- rf_wr_idx  output  5  register-file write index.
- rf_wr_data  output  XLEN  register-file write data.
- mem_req  output  1  store request to memory.
- mem_addr  output  XLEN  store address.
- mem_wdata  output  XLEN  store data, zero-extended from in_size.
- mem_size  output  2  store size.
- mem_ack  input  1  memory accepted current request.
- sb_empty  output  1  store buffer empty and no request outstanding.
- misalign  output  1  one-cycle pulse when a store is dropped for misalignment.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: rf_wr_en=0, rf_wr_idx=0, rf_wr_data=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_size=0, misalign=0.
  - Buffer and FSM: store buffer empty, pointers and count cleared, sb_empty=1, drain FSM in IDLE.
  - Reset mid-transaction abandons buffered stores; mem_req drops immediately.
- Accept: a transfer occurs when in_valid && in_ready.
  - in_ready = (count < SB_DEPTH), combinational from registered count.
  - in_ready stays low when full even if a pop occurs in the same cycle.
  - Register results are always accepted while in_ready=1.
- Register path: on accepted non-store, next cycle rf_wr_en=1, rf_wr_idx=in_dest, rf_wr_data=in_data.
  - in_dest==0 gives rf_wr_en=0 (x0 never written).
  - rf_wr_en is otherwise 0. Latency is exactly 1 cycle.
- Store path: on accepted store, check alignment.
  - Misaligned when the address bits below log2(size bytes) are nonzero (half: addr[0]; word: addr[1:0]; double: addr[2:0]).
  - Misaligned store: not enqueued; misalign=1 for the next cycle only.
  - Aligned store: enqueued with addr, size, and data masked to size (upper bits zeroed).
- Buffer: circular FIFO of SB_DEPTH entries.
  - Write/read pointers wrap modulo SB_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - Strict in-order drain.
- Drain FSM:
  - IDLE: if count>0, load head entry into mem_addr/mem_wdata/mem_size, assert mem_req, go to REQ.
  - REQ: hold mem_req and all mem_* stable until mem_ack=1. On ack, pop head, deassert mem_req next cycle, return to IDLE.
  - Minimum 2 cycles per store.
  - mem_ack outside REQ is ignored.
- sb_empty = (count==0) && (state==IDLE).
- Pipeline control: no flush input. The upstream stage stalls on in_ready=0 and must hold its inputs stable.

Test Plan:
- Register write: accept in_dest=5, in_data=0x1234 -> next cycle rf_wr_en=1, rf_wr_idx=5, rf_wr_data=0x1234. Then in_dest=0 -> rf_wr_en stays 0.
- Single store: sw addr=0x1000, data=0xFFFFFFFF_DEADBEEF -> mem_req=1, mem_addr=0x1000, mem_wdata=0x00000000_DEADBEEF, mem_size=2. Hold mem_ack=0 for 3 cycles: outputs stable. mem_ack=1 -> mem_req=0 next cycle, sb_empty=1.
- Full buffer: hold mem_ack=0, push 5 aligned sd stores -> after the 4th, in_ready=0 and the 5th is held off. Ack one -> in_ready=1. Drained addresses appear in push order.
- Wrap-around: push and drain 10 stores with mixed sizes -> all 10 appear in order with correct masked data, no loss or duplication.
- Misalignment: sh addr=0x1001 -> misalign pulses once, mem_req never asserts, sb_empty stays 1. sd addr=0x2008 -> issued normally.
- Reset mid-request: assert reset while mem_req=1 with 3 entries queued -> mem_req=0 immediately, sb_empty=1. After release, no stale request is issued.
